alu_writeback: RTL and testbench

//   Destination end of the ALU datapath. The ALU reads 16-bit operands as little-endian byte pairs from

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_writeback.sv | 103 ++++++++++
 tb/tb_alu_writeback.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU package: writeback FSM encoding, PSW flag positions and operand size codes.
package alu_pkg;

    // Writeback sequencer states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWrLo = 2'd1,
        StWrHi = 2'd2,
        StDone = 2'd3
    } wb_state_e;

    // PSW flag bit positions
    localparam int unsigned PSW_C = 0;
    localparam int unsigned PSW_Z = 1;
    localparam int unsigned PSW_N = 2;
    localparam int unsigned PSW_V = 4;

    // Operand size as carried on res_byte
    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

endpackage

// File: rtl/alu_writeback.sv
// ALU writeback: accepts a result over valid/ready, stores it to byte-wide memory
// low byte first, and holds the architectural PSW register.
module alu_writeback
    import alu_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter logic [15:0] PSW_RESET = 16'h0000
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_data,
    input  logic [ADDR_W-1:0] res_addr,
    input  logic              res_byte,
    input  logic [15:0]       psw_in,
    input  logic              psw_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [15:0]       psw_o,
    output logic              wb_done
);

    wb_state_e         state_q, state_d;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              byte_q;
    logic [15:0]       psw_q;
    logic              accept;
    logic [7:0]        lane_byte;

    assign accept = (state_q == StIdle) && res_valid;

    // Byte-lane select: high byte only while in the second write phase
    assign lane_byte = (state_q == StWrHi) ? data_q[DATA_W-1 -: 8] : data_q[7:0];

    assign psw_o = psw_q;

    // State register, latched transaction fields and PSW register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            addr_q  <= '0;
            byte_q  <= SIZE_WORD;
            psw_q   <= PSW_RESET;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= res_data;
                addr_q <= res_addr;
                byte_q <= res_byte;
                if (psw_we) begin
                    psw_q <= psw_in;
                end
            end
        end
    end

    // Next state and outputs, decoded from registered state and latched fields
    always_comb begin
        state_d   = state_q;
        res_ready = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wb_done   = 1'b0;
        unique case (state_q)
            StIdle: begin
                res_ready = 1'b1;
                if (res_valid) begin
                    state_d = StWrLo;
                end
            end
            StWrLo: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = lane_byte;
                if (mem_ready) begin
                    state_d = (byte_q == SIZE_BYTE) ? StDone : StWrHi;
                end
            end
            StWrHi: begin
                mem_we    = 1'b1;
                // Natural ADDR_W-bit wrap: top address rolls over to zero
                mem_addr  = addr_q + ADDR_W'(1);
                mem_wdata = lane_byte;
                if (mem_ready) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                wb_done = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed cases plus randomized transactions
// compared against an expected byte-write list built from the result/address/size.
module tb_alu_writeback;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [15:0] res_addr;
    logic        res_byte;
    logic [15:0] psw_in;
    logic        psw_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_ready;
    logic [15:0] psw_o;
    logic        wb_done;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [15:0] exp_psw;
    logic [15:0] obs_addr[$];
    logic [7:0]  obs_data[$];
    int          done_cnt;

    alu_writeback #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .PSW_RESET(16'h0000)
    ) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_addr (res_addr),
        .res_byte (res_byte),
        .psw_in   (psw_in),
        .psw_we   (psw_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_ready(mem_ready),
        .psw_o    (psw_o),
        .wb_done  (wb_done)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record what the memory takes on the coming edge, then advance one cycle
    task automatic tick();
        if (mem_we && mem_ready) begin
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_wdata);
        end
        if (wb_done) done_cnt++;
        @(posedge Clock);
        #1;
    endtask

    // One full transaction; rnd enables memory stalls and junk res_valid while busy
    task automatic run_txn(input logic [15:0] d, input logic [15:0] a, input logic b,
                           input logic [15:0] p, input logic pw, input bit rnd);
        int          guard;
        int          n_exp;
        logic [15:0] ea[2];
        logic [7:0]  ed[2];
        ea[0] = a;
        ed[0] = d[7:0];
        ea[1] = 16'(a + 16'd1);
        ed[1] = d[15:8];
        n_exp = b ? 1 : 2;
        obs_addr.delete();
        obs_data.delete();
        done_cnt = 0;
        res_data  = d;
        res_addr  = a;
        res_byte  = b;
        psw_in    = p;
        psw_we    = pw;
        res_valid = 1'b1;
        guard = 0;
        while (!res_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("ready_timeout", 32'(guard < 20), 1);
        tick();
        if (pw) exp_psw = p;
        res_valid = 1'b0;
        res_data  = 16'($urandom);
        res_addr  = 16'($urandom);
        psw_in    = 16'($urandom);
        psw_we    = 1'($urandom);
        check("psw_after_accept", psw_o, exp_psw);
        check("busy_not_ready", res_ready, 0);
        guard = 0;
        while (!wb_done && guard < 200) begin
            mem_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd) res_valid = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        check("done_timeout", 32'(guard < 200), 1);
        check("done_mem_we", mem_we, 0);
        check("done_not_ready", res_ready, 0);
        check("write_count", obs_addr.size(), n_exp);
        for (int i = 0; i < n_exp && i < obs_addr.size(); i++) begin
            check("write_addr", obs_addr[i], ea[i]);
            check("write_data", obs_data[i], ed[i]);
        end
        res_valid = 1'b0;
        tick();
        check("idle_ready", res_ready, 1);
        check("single_done", done_cnt, 1);
        check("psw_hold", psw_o, exp_psw);
    endtask

    initial begin
        logic [15:0] ra;
        res_valid = 1'b0;
        res_data  = '0;
        res_addr  = '0;
        res_byte  = 1'b0;
        psw_in    = '0;
        psw_we    = 1'b0;
        mem_ready = 1'b0;
        exp_psw   = 16'h0000;
        done_cnt  = 0;
        #1;
        check("rst_ready", res_ready, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_done", wb_done, 0);
        check("rst_psw", psw_o, 16'h0000);
        repeat (2) @(posedge Clock);
        #1;
        Reset_n = 1'b1;

        // Word write with exact cycle timing
        res_data  = 16'hBEEF;
        res_addr  = 16'h0010;
        res_byte  = 1'b0;
        res_valid = 1'b1;
        mem_ready = 1'b1;
        tick();
        res_valid = 1'b0;
        res_data  = 16'h0000;
        check("w_c1_we", mem_we, 1);
        check("w_c1_addr", mem_addr, 16'h0010);
        check("w_c1_data", mem_wdata, 8'hEF);
        tick();
        check("w_c2_we", mem_we, 1);
        check("w_c2_addr", mem_addr, 16'h0011);
        check("w_c2_data", mem_wdata, 8'hBE);
        tick();
        check("w_c3_done", wb_done, 1);
        check("w_c3_we", mem_we, 0);
        tick();
        check("w_c4_ready", res_ready, 1);
        check("w_c4_done", wb_done, 0);

        // Byte write, wrap-around word, PSW commit and hold
        run_txn(16'h12AB, 16'h0020, 1'b1, 16'h0000, 1'b0, 0);
        run_txn(16'h1234, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 0);
        run_txn(16'h5555, 16'h0100, 1'b0, 16'h0013, 1'b1, 0);
        run_txn(16'h6666, 16'h0200, 1'b1, 16'h0000, 1'b0, 0);
        check("psw_kept", psw_o, 16'h0013);

        // Stall in WR_LO for 3 cycles with a second result pending
        obs_addr.delete();
        obs_data.delete();
        res_data  = 16'hA1B2;
        res_addr  = 16'h0300;
        res_byte  = 1'b0;
        psw_we    = 1'b0;
        res_valid = 1'b1;
        mem_ready = 1'b0;
        tick();
        res_data = 16'hC3D4;
        res_addr = 16'h0400;
        res_byte = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_we", mem_we, 1);
            check("stall_addr", mem_addr, 16'h0300);
            check("stall_data", mem_wdata, 8'hB2);
            check("stall_ready", res_ready, 0);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        check("stall_hi_addr", mem_addr, 16'h0301);
        check("stall_hi_data", mem_wdata, 8'hA1);
        tick();
        check("stall_done", wb_done, 1);
        tick();
        check("stall_idle_ready", res_ready, 1);
        tick();
        res_valid = 1'b0;
        check("second_addr", mem_addr, 16'h0400);
        check("second_data", mem_wdata, 8'hD4);
        tick();
        check("second_done", wb_done, 1);
        tick();
        check("stall_writes", obs_addr.size(), 3);

        // Reset in the middle of a transaction
        run_txn(16'h7777, 16'h0500, 1'b0, 16'h00F1, 1'b1, 0);
        res_data  = 16'h8888;
        res_addr  = 16'h0600;
        res_byte  = 1'b0;
        res_valid = 1'b1;
        mem_ready = 1'b0;
        tick();
        res_valid = 1'b0;
        check("mid_we_before", mem_we, 1);
        Reset_n = 1'b0;
        #1;
        exp_psw = 16'h0000;
        check("mid_rst_ready", res_ready, 1);
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_done", wb_done, 0);
        check("mid_rst_psw", psw_o, 16'h0000);
        res_valid = 1'b1;
        @(posedge Clock);
        #1;
        check("held_in_rst_we", mem_we, 0);
        Reset_n = 1'b1;
        run_txn(16'h9ABC, 16'h0700, 1'b0, 16'h0000, 1'b0, 0);

        // Randomized traffic with stalls and spurious res_valid
        for (int n = 0; n < 40; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            run_txn(16'($urandom), ra, 1'($urandom_range(0, 1)), 16'($urandom),
                    1'($urandom_range(0, 1)), 1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
